bcd_timer_display: RTL
======================

// Module: bcd_timer_display
// PURPOSE
//  Parametrised multi-digit BCD up/down timer with built-in tick prescaler and 7-segment drive.
//  Successor to the two-digit down counter / splitter / decoder chain.
//  Counts directly in BCD, so no binary-to-digit split stage is needed.
//  Adds parallel load, direction select, wrap/stop mode and terminal flags.
//  Sits between the board clock and the HEX displays.
// PARAMETERS
//  DIGITS    2          number of BCD digits / 7-seg displays (1..8)
//  CLK_DIV   25000000   clk cycles per count tick (>=2)
//  RESET_VAL 8'h30      BCD value loaded on reset; width DIGITS*4; digits must be 0-9
//  BLANK_LZ  0          1 = blank leading zero digits (MS digits only, digit 0 never blanked)
// PORTS
//  clk       in   1           system clock, all state on rising edge
//  reset     in   1           asynchronous, active-low reset
//  sw        in   1           direction: 1 = count up, 0 = count down
//  pause     in   1           1 = freeze prescaler and count
//  wrap      in   1           1 = wrap at terminal value, 0 = stop at terminal value
//  load      in   1           synchronous load strobe
//  load_val  in   DIGITS*4    BCD value to load
//  count_bcd out  DIGITS*4    current count, digit i at [4i+3:4i]
//  seg       out  DIGITS*7    active-low segments, digit i at [7i+6:7i]; bit0=a ... bit6=g
//  tc        out  1           1-cycle pulse on a wrap event
//  expired   out  1           level: held at terminal value in stop mode
// BEHAVIOUR
//  Reset (reset=0, async): count=RESET_VAL, prescaler=0, tc=0, expired=0.
//  - seg shows RESET_VAL immediately (combinational from count).
//  Prescaler: counts 0..CLK_DIV-1; tick = 1 for one cycle when it equals CLK_DIV-1, then returns to 0.
//  - pause=1 holds the prescaler value; it does not clear it.
//  Priority per edge: load > pause > tick.
//  Load (load=1): count<=load_val, prescaler<=0, expired<=0, tc<=0.
//  - Any load_val digit >9 is clamped to 9.
//  Tick, sw=1 (up): BCD increment, with carry from digit i to i+1 when digit i = 9 -> 0.
//  Tick, sw=0 (down): BCD decrement, with borrow when digit i = 0 -> 9.
//  Terminal value: all 9s when counting up, all 0s when counting down.
//  - Tick at terminal, wrap=1: count jumps to the opposite end (99..9 -> 0, 0 -> 99..9).
//    tc=1 for exactly that cycle.
//  - Tick at terminal, wrap=0: count holds, expired<=1, tc stays 0.
//  expired clears only on load, reset, or a tick that moves count off the held value.
//  - Example: direction flipped, so the terminal is now the other end.
//  sw and wrap are sampled at each tick; a change between ticks takes effect at the next tick.
//  count_bcd, tc and expired are registered; count changes on the edge where tick=1.
//  seg is decoded combinationally from count_bcd.
//  Encoding (gfedcba, active-low):
//  - 0=1000000  1=1111001  2=0100100  3=0110000  4=0011001
//  - 5=0010010  6=0000010  7=1111000  8=0000000  9=0010000
//  Blanking with BLANK_LZ=1: digit i (i>0) is blanked to 1111111 while digits DIGITS-1..i are all 0.
//  Reset asserted mid-prescale or mid-tick: all state returns to reset values at once; no tick is lost
//  or owed after release.
// TESTING (DIGITS=2, CLK_DIV=4, RESET_VAL=8'h30, BLANK_LZ=0 unless noted)
//  1 Reset release, sw=0 wrap=1, 4 clks -> count_bcd=8'h29, seg[13:7]=0100100, seg[6:0]=0010000.
//  2 load 8'h01, sw=0 wrap=1 -> ticks give 00 then 99; tc=1 for one clk on the 00->99 edge only.
//  3 load 8'h98, sw=1 wrap=0 -> 99 after 1 tick; next tick holds 99, expired=1, tc=0.
//    Then load 8'h10 -> expired=0.
//  4 pause=1 for 10 clks after 2 prescaler cycles -> count unchanged.
//    After release, next tick comes after exactly 2 more clks.
//  5 reset pulsed low between edges at count 8'h17 -> count_bcd=8'h30, tc=0, expired=0 with no clk edge.
//  6 load 8'hA5 -> count 8'h95.
//    BLANK_LZ=1 with load 8'h05 -> seg[13:7]=1111111, seg[6:0]=0010010.

Source files
------------

// File: rtl/bcd_timer_display.sv
// Multi-digit BCD up/down timer with an internal tick prescaler and active-low 7-segment outputs.
// The count is held in BCD throughout, so each digit drives its display decoder directly.
module bcd_timer_display #(
    parameter int                   DIGITS    = 2,
    parameter int                   CLK_DIV   = 25000000,
    parameter logic [DIGITS*4-1:0]  RESET_VAL = 8'h30,
    parameter bit                   BLANK_LZ  = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw,
    input  logic                  pause,
    input  logic                  wrap,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_val,
    output logic [DIGITS*4-1:0]   count_bcd,
    output logic [DIGITS*7-1:0]   seg,
    output logic                  tc,
    output logic                  expired
);

    localparam int            PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0]          presc_reg;
    logic [DIGITS*4-1:0]    count_reg;
    logic                   tc_reg;
    logic                   expired_reg;

    logic [DIGITS*4-1:0]    count_up;
    logic [DIGITS*4-1:0]    count_dn;
    logic [DIGITS*4-1:0]    load_clamped;
    logic [DIGITS:0]        carry;
    logic [DIGITS:0]        borrow;
    logic [DIGITS:0]        zero_above;
    logic                   at_term;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign carry[0]           = 1'b1;
    assign borrow[0]          = 1'b1;
    assign zero_above[DIGITS] = 1'b1;

    // Per-digit carry/borrow ripple; carry[DIGITS] means all 9s, borrow[DIGITS] means all 0s.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] d;
            logic [3:0] lv;
            assign d  = count_reg[4*gi +: 4];
            assign lv = load_val[4*gi +: 4];

            assign carry[gi+1]  = carry[gi]  & (d == 4'd9);
            assign borrow[gi+1] = borrow[gi] & (d == 4'd0);
            assign count_up[4*gi +: 4] = !carry[gi]  ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
            assign count_dn[4*gi +: 4] = !borrow[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            assign load_clamped[4*gi +: 4] = (lv > 4'd9) ? 4'd9 : lv;

            assign zero_above[gi] = zero_above[gi+1] & (d == 4'd0);

            if (gi == 0) begin : g_lsd
                assign seg[6:0] = seg7(d);
            end else begin : g_msd
                assign seg[7*gi +: 7] = (BLANK_LZ && zero_above[gi]) ? 7'b1111111 : seg7(d);
            end
        end
    endgenerate

    assign at_term = sw ? carry[DIGITS] : borrow[DIGITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_reg   <= '0;
            count_reg   <= RESET_VAL;
            tc_reg      <= 1'b0;
            expired_reg <= 1'b0;
        end else begin
            tc_reg <= 1'b0;
            if (load) begin
                count_reg   <= load_clamped;
                presc_reg   <= '0;
                expired_reg <= 1'b0;
            end else if (!pause) begin
                if (presc_reg == PRE_LAST) begin
                    presc_reg <= '0;
                    if (at_term && !wrap) begin
                        expired_reg <= 1'b1;
                    end else begin
                        // Incrementing all 9s or decrementing all 0s naturally wraps to the opposite end.
                        count_reg   <= sw ? count_up : count_dn;
                        expired_reg <= 1'b0;
                        tc_reg      <= at_term;
                    end
                end else begin
                    presc_reg <= presc_reg + PW'(1);
                end
            end
        end
    end

    assign count_bcd = count_reg;
    assign tc        = tc_reg;
    assign expired   = expired_reg;

endmodule
